// File: rtl/rbs_serial_if.sv
// rbs_serial_if: start/busy/done handshake and data bus for the serial subtractor.
//   start, operand_a, operand_b : requester -> subtractor
//   busy, done, result, borrow_out, flags : subtractor -> requester
// The master modport is the requesting side; the slave modport is the subtractor.
interface rbs_serial_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             borrow_out;
    logic [3:0]       flags;

    modport master (
        output start,
        output operand_a,
        output operand_b,
        input  busy,
        input  done,
        input  result,
        input  borrow_out,
        input  flags
    );

    modport slave (
        input  start,
        input  operand_a,
        input  operand_b,
        output busy,
        output done,
        output result,
        output borrow_out,
        output flags
    );
endinterface

// File: rtl/rbs_serial.sv
// rbs_serial: multi-cycle ripple-borrow subtractor, result = operand_a - operand_b.
// Processes BITS_PER_CYCLE bits per clock, LSB chunk first, and reports the flags
// word {N, Z, B, V} in the same layout as the companion ripple-carry adder.
// Ports:
//   CLK  : clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : rbs_serial_if slave modport (start/operands in; busy/done/result/borrow_out/flags out)
module rbs_serial #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input logic         CLK,
    input logic         RST,
    rbs_serial_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    generate
        if (BITS_PER_CYCLE == 0 || BITS_PER_CYCLE > WIDTH || (WIDTH % BITS_PER_CYCLE) != 0)
        begin : g_bad_chunk
            $error("rbs_serial: BITS_PER_CYCLE must divide WIDTH");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, diff_q;
    logic             borrow_q;
    logic [CW-1:0]    count_q;
    logic             a_msb_q, b_msb_q;
    logic [WIDTH-1:0] result_q;
    logic             bout_q;
    logic [3:0]       flags_q;

    logic                      accept;
    logic                      last_chunk;
    logic [BITS_PER_CYCLE:0]   chunk_ext;
    logic [WIDTH-1:0]          diff_next;
    logic                      borrow_next;
    logic [3:0]                flags_next;

    assign accept     = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_chunk = (state_q == ST_RUN) && (count_q == LAST_CHUNK);

    // Zero-extended subtraction: the extra top bit is set exactly when the chunk borrows.
    assign chunk_ext = {1'b0, a_q[BITS_PER_CYCLE-1:0]}
                     - {1'b0, b_q[BITS_PER_CYCLE-1:0]}
                     - {{BITS_PER_CYCLE{1'b0}}, borrow_q};
    assign borrow_next = chunk_ext[BITS_PER_CYCLE];

    // New chunk enters at the top; after NCHUNK steps the LSB chunk has reached bit 0.
    assign diff_next = (diff_q >> BITS_PER_CYCLE)
                     | (WIDTH'(chunk_ext[BITS_PER_CYCLE-1:0]) << (WIDTH - BITS_PER_CYCLE));

    // Operand signs are kept aside because a_q/b_q are shifted away during RUN.
    always_comb begin
        flags_next    = 4'b0000;
        flags_next[3] = diff_next[WIDTH-1];
        flags_next[2] = ~|diff_next;
        flags_next[1] = borrow_next;
        flags_next[0] = (a_msb_q != b_msb_q) && (diff_next[WIDTH-1] != a_msb_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (last_chunk) state_d = ST_DONE;
            ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            result_q <= '0;
            bout_q   <= 1'b0;
            flags_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q      <= bus.operand_a;
                b_q      <= bus.operand_b;
                a_msb_q  <= bus.operand_a[WIDTH-1];
                b_msb_q  <= bus.operand_b[WIDTH-1];
                diff_q   <= '0;
                borrow_q <= 1'b0;
                count_q  <= '0;
            end else if (state_q == ST_RUN) begin
                a_q      <= a_q >> BITS_PER_CYCLE;
                b_q      <= b_q >> BITS_PER_CYCLE;
                diff_q   <= diff_next;
                borrow_q <= borrow_next;
                count_q  <= count_q + 1'b1;
                if (last_chunk) begin
                    result_q <= diff_next;
                    bout_q   <= borrow_next;
                    flags_q  <= flags_next;
                end
            end
        end
    end

    assign bus.busy       = (state_q == ST_RUN);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.result     = result_q;
    assign bus.borrow_out = bout_q;
    assign bus.flags      = flags_q;
endmodule

// File: tb/tb_rbs_serial.sv
// tb_rbs_serial: scoreboard bench for rbs_serial. Stimulus pushes hand-computed expected
// results (with the cycle at which done must appear); per-DUT monitors pop and compare.
module tb_rbs_serial;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    rbs_serial_if #(.WIDTH(32)) if1 ();
    rbs_serial_if #(.WIDTH(32)) if4 ();

    rbs_serial #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut1 (.CLK(CLK), .RST(RST), .bus(if1.slave));
    rbs_serial #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (.CLK(CLK), .RST(RST), .bus(if4.slave));

    typedef struct {
        logic [31:0] res;
        logic        bo;
        logic [3:0]  fl;
        int unsigned cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    int unsigned cyc = 0;
    int checks = 0;
    int passed = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic compare(input string tag, input exp_t e, input logic [31:0] r,
                           input logic bo, input logic [3:0] fl);
        check({tag, " result"}, r, e.res);
        check({tag, " borrow_out"}, {31'd0, bo}, {31'd0, e.bo});
        check({tag, " flags"}, {28'd0, fl}, {28'd0, e.fl});
        check({tag, " done cycle"}, cyc, e.cyc);
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            if (if1.busy && if1.done) check("dut1 busy&done", 32'd1, 32'd0);
            if (if4.busy && if4.done) check("dut4 busy&done", 32'd1, 32'd0);
            if (if1.done) begin
                if (q1.size() == 0) check("dut1 unexpected done", 32'd1, 32'd0);
                else compare("dut1", q1.pop_front(), if1.result, if1.borrow_out, if1.flags);
            end
            if (if4.done) begin
                if (q4.size() == 0) check("dut4 unexpected done", 32'd1, 32'd0);
                else compare("dut4", q4.pop_front(), if4.result, if4.borrow_out, if4.flags);
            end
        end
    end

    // Called at a negedge: the next posedge accepts, so done is seen at cycle cyc+1+n.
    task automatic issue1(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                          input logic bo, input logic [3:0] fl);
        exp_t e;
        e.res = r; e.bo = bo; e.fl = fl; e.cyc = cyc + 1 + 32;
        q1.push_back(e);
        if1.start = 1'b1; if1.operand_a = a; if1.operand_b = b;
        @(negedge CLK);
        if1.start = 1'b0;
    endtask

    task automatic drain1();
        int n = 0;
        while (q1.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (q1.size() != 0) begin
            check("dut1 timeout", q1.size(), 32'd0);
            q1.delete();
        end
        @(negedge CLK);
    endtask

    task automatic wait_cyc(input int unsigned target);
        int n = 0;
        while (cyc != target && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (cyc != target) check("wait_cyc timeout", cyc, target);
    endtask

    initial begin
        int unsigned d;
        exp_t e;
        if1.start = 1'b0; if1.operand_a = '0; if1.operand_b = '0;
        if4.start = 1'b0; if4.operand_a = '0; if4.operand_b = '0;
        #1;
        check("reset busy", {31'd0, if1.busy}, 32'd0);
        check("reset done", {31'd0, if1.done}, 32'd0);
        check("reset result", if1.result, 32'd0);
        check("reset flags", {28'd0, if1.flags}, 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        issue1(32'd10, 32'd5, 32'd5, 1'b0, 4'b0000);
        drain1();
        issue1(-32'sd10, -32'sd5, 32'hFFFF_FFFB, 1'b1, 4'b1010);
        drain1();
        issue1(32'd0, 32'd0, 32'd0, 1'b0, 4'b0100);
        drain1();
        issue1(32'd0, 32'd1, 32'hFFFF_FFFF, 1'b1, 4'b1010);
        drain1();
        issue1(32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 4'b0001);
        drain1();
        issue1(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 4'b1011);
        drain1();

        // Start while busy is ignored; operand changes after acceptance have no effect.
        d = cyc + 1 + 32;
        issue1(32'd10, 32'd5, 32'd5, 1'b0, 4'b0000);
        wait_cyc(d - 32 + 5);
        if1.start = 1'b1; if1.operand_a = 32'd100; if1.operand_b = 32'd1;
        @(negedge CLK);
        if1.start = 1'b0; if1.operand_a = 32'd7; if1.operand_b = 32'd3;
        // Hold start through DONE: back-to-back acceptance with no IDLE cycle.
        wait_cyc(d - 1);
        if1.start = 1'b1; if1.operand_a = 32'd20; if1.operand_b = 32'd30;
        e.res = 32'hFFFF_FFF6; e.bo = 1'b1; e.fl = 4'b1010; e.cyc = d + 1 + 32;
        q1.push_back(e);
        wait_cyc(d + 1);
        check("back-to-back busy", {31'd0, if1.busy}, 32'd1);
        if1.start = 1'b0;
        drain1();

        // Reset mid-RUN: outputs clear at once and the aborted op never completes.
        if1.operand_a = 32'd9; if1.operand_b = 32'd2;
        if1.start = 1'b1;
        @(negedge CLK);
        if1.start = 1'b0;
        repeat (10) @(negedge CLK);
        check("pre-reset busy", {31'd0, if1.busy}, 32'd1);
        #2 RST = 1'b1;
        #1;
        check("mid-run reset busy", {31'd0, if1.busy}, 32'd0);
        check("mid-run reset done", {31'd0, if1.done}, 32'd0);
        check("mid-run reset result", if1.result, 32'd0);
        check("mid-run reset flags", {28'd0, if1.flags}, 32'd0);
        check("mid-run reset borrow", {31'd0, if1.borrow_out}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (40) @(negedge CLK);
        issue1(32'h1234_5678, 32'h0000_0078, 32'h1234_5600, 1'b0, 4'b0000);
        drain1();

        // Four bits per cycle: done eight edges after acceptance.
        e.res = 32'd5; e.bo = 1'b0; e.fl = 4'b0000; e.cyc = cyc + 1 + 8;
        q4.push_back(e);
        if4.start = 1'b1; if4.operand_a = 32'd10; if4.operand_b = 32'd5;
        @(negedge CLK);
        if4.start = 1'b0;
        e.res = 32'h7FFF_FFFF; e.bo = 1'b0; e.fl = 4'b0001; e.cyc = cyc + 1 + 8;
        repeat (12) @(negedge CLK);
        e.cyc = cyc + 1 + 8;
        q4.push_back(e);
        if4.start = 1'b1; if4.operand_a = 32'h8000_0000; if4.operand_b = 32'd1;
        @(negedge CLK);
        if4.start = 1'b0;
        repeat (20) @(negedge CLK);
        check("dut4 queue empty", q4.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
